// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: ping-pong line-buffer sprite compositor.
// The front buffer feeds the VGA colour outputs for the current line. At the
// same time the back buffer is cleared and line L+1 is drawn into it from the
// sprite table and an external bitmap ROM that has one clock of read latency.
// Optional feature macro: SPRITE_COLLISION_EN. It adds the sticky collision
// output and a per-pixel occupancy bit kept alongside the back buffer.
module sprite_line_renderer #(
  parameter int          NUM_SPRITES = 20,
  parameter int          SPRITE_DIM  = 32,
  parameter int          TYPE_W      = 5,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_TOTAL     = 525
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_SPRITES*24-1:0]                 gl_array,
  input  logic [9:0]                                VGA_HCOUNT,
  input  logic [9:0]                                VGA_VCOUNT,
  output logic [TYPE_W+2*$clog2(SPRITE_DIM)-1:0]    rom_addr,
  input  logic [23:0]                               rom_data,
  output logic [7:0]                                VGA_R,
  output logic [7:0]                                VGA_G,
  output logic [7:0]                                VGA_B,
  output logic                                      busy,
  output logic                                      overrun
`ifdef SPRITE_COLLISION_EN
  ,
  output logic                                      collision
`endif
);

  localparam int DIM_W = $clog2(SPRITE_DIM);
  localparam int IDX_W = $clog2(NUM_SPRITES);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAW, S_DONE} state_t;

  state_t            state_q;
  logic              front_sel_q;   // 1: buf1 is front, buf0 is back
  logic [9:0]        prev_h_q;
  logic [9:0]        tgt_q;
  logic [9:0]        clr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [9:0]        x_q;
  logic [DIM_W-1:0]  row_q;
  logic [TYPE_W-1:0] type_q;
  logic [DIM_W-1:0]  col_q;
  logic              drain_q;
  logic              pend_q;        // rom_data this clk belongs to pend_addr_q
  logic [10:0]       pend_addr_q;
  logic              busy_q;
  logic              overrun_q;
  logic [23:0]       pix_q;

  logic [23:0] buf0 [H_ACTIVE];
  logic [23:0] buf1 [H_ACTIVE];

  logic [23:0] tbl [NUM_SPRITES];
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_tbl
    assign tbl[g] = gl_array[24*g +: 24];
  end

  // Line start: hcount returns to 0 (tolerant of hcount held several clocks).
  logic        line_start;
  logic [10:0] vnext;
  logic [9:0]  tgt_d;
  assign line_start = (VGA_HCOUNT == 10'd0) && (prev_h_q != 10'd0);
  assign vnext      = {1'b0, VGA_VCOUNT} + 11'd1;
  assign tgt_d      = (vnext == 11'(V_TOTAL)) ? 10'd0 : vnext[9:0];

  // Current scan entry fields and the row-overlap test against target line.
  logic [23:0] ent;
  logic [9:0]  ent_x;
  logic [9:0]  ent_y;
  logic [TYPE_W-1:0] ent_type;
  logic [10:0] y_end;
  logic        skip;
  assign ent      = tbl[idx_q];
  assign ent_x    = ent[23:14];
  assign ent_y    = {1'b0, ent[13:5]};
  assign ent_type = ent[TYPE_W-1:0];
  assign y_end    = {1'b0, ent_y} + 11'(SPRITE_DIM);
  assign skip     = (ent_type == '0) || (tgt_q < ent_y) || ({1'b0, tgt_q} >= y_end);

  assign rom_addr = {type_q, row_q, col_q};

  // Back-buffer write port: clear pass, or an opaque, on-screen ROM pixel.
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_occ;
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 10'd0;
    wr_data = BG_COLOR;
    wr_occ  = 1'b0;
    if (line_start) begin
      wr_en = 1'b0;   // the back buffer is about to become the front
    end else if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_q;
    end else if (pend_q && (rom_data != KEY_COLOR) && (pend_addr_q < 11'(H_ACTIVE))) begin
      wr_en   = 1'b1;
      wr_addr = pend_addr_q[9:0];
      wr_data = rom_data;
      wr_occ  = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Line buffer storage: only the back buffer is ever written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel_q) buf0[wr_addr] <= wr_data;
      else             buf1[wr_addr] <= wr_data;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic occ0 [H_ACTIVE];
  logic occ1 [H_ACTIVE];
  logic coll_hit;
  logic collision_q;
  assign coll_hit  = wr_en && wr_occ && (front_sel_q ? occ0[wr_addr] : occ1[wr_addr]);
  assign collision = collision_q;

  // Occupancy storage: cleared with the colour, set by every opaque draw.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_sel_q) occ0[wr_addr] <= wr_occ;
      else             occ1[wr_addr] <= wr_occ;
    end
  end
`endif

  // At line start the display already reads the newly swapped front buffer.
  logic rd_sel;
  assign rd_sel = line_start ? ~front_sel_q : front_sel_q;

  // Display pixel from the front buffer, one clock latency, blanked off-screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q <= 24'h000000;
    end else if ((VGA_HCOUNT < 10'(H_ACTIVE)) && (VGA_VCOUNT < 10'(V_ACTIVE))) begin
      pix_q <= rd_sel ? buf1[VGA_HCOUNT] : buf0[VGA_HCOUNT];
    end else begin
      pix_q <= 24'h000000;
    end
  end

  assign VGA_R   = pix_q[23:16];
  assign VGA_G   = pix_q[15:8];
  assign VGA_B   = pix_q[7:0];
  assign busy    = busy_q;
  assign overrun = overrun_q;

  // Render FSM: swap and restart at each line start, then clear, scan, draw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      prev_h_q    <= 10'd0;
      tgt_q       <= 10'd0;
      clr_q       <= 10'd0;
      idx_q       <= '0;
      x_q         <= 10'd0;
      row_q       <= '0;
      type_q      <= '0;
      col_q       <= '0;
      drain_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 11'd0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SPRITE_COLLISION_EN
      collision_q <= 1'b0;
`endif
    end else begin
      prev_h_q <= VGA_HCOUNT;
      pend_q   <= 1'b0;
`ifdef SPRITE_COLLISION_EN
      if (coll_hit) collision_q <= 1'b1;
`endif
      if (line_start) begin
        front_sel_q <= ~front_sel_q;
        tgt_q       <= tgt_d;
        clr_q       <= 10'd0;
        col_q       <= '0;
        drain_q     <= 1'b0;
        if ((state_q == S_CLEAR) || (state_q == S_SCAN) || (state_q == S_DRAW)) overrun_q <= 1'b1;
`ifdef SPRITE_COLLISION_EN
        if (tgt_d == 10'd0) collision_q <= 1'b0;
`endif
        if (tgt_d < 10'(V_ACTIVE)) begin
          state_q <= S_CLEAR;
          busy_q  <= 1'b1;
        end else begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          S_CLEAR: begin
            if (clr_q == 10'(H_ACTIVE - 1)) begin
              state_q <= S_SCAN;
              idx_q   <= IDX_W'(NUM_SPRITES - 1);
            end else begin
              clr_q <= clr_q + 10'd1;
            end
          end
          S_SCAN: begin
            if (!skip) begin
              x_q     <= ent_x;
              row_q   <= DIM_W'(tgt_q - ent_y);
              type_q  <= ent_type;
              col_q   <= '0;
              drain_q <= 1'b0;
              state_q <= S_DRAW;
            end else if (idx_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
          S_DRAW: begin
            if (!drain_q) begin
              pend_q      <= 1'b1;
              pend_addr_q <= {1'b0, x_q} + 11'(col_q);
              if (col_q == DIM_W'(SPRITE_DIM - 1)) drain_q <= 1'b1;
              else                                 col_q   <= col_q + 1'b1;
            end else if (idx_q == '0) begin
              drain_q <= 1'b0;
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              drain_q <= 1'b0;
              idx_q   <= idx_q - 1'b1;
              state_q <= S_SCAN;
            end
          end
          S_IDLE, S_DONE: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
